// File: rtl/score_pkg.sv
// Shared types, sprite geometry and BCD helper for the score display block.
package score_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_APPLY, ST_COMMIT} state_t;

  localparam int          DIGIT_W  = 32;
  localparam int          DIGIT_H  = 32;
  localparam logic [11:0] BG_COLOR = 12'hFFF;

  // Ripple +1 across four BCD nibbles; 9999 holds rather than wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c           = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_ctrl_rom_bank.sv
// 32x32 seven-segment digit sprite ROMs (registered read) and the bank that
// selects one of them by a digit select registered alongside the ROM address.
module digit_rom
  import score_pkg::*;
#(
  parameter logic [6:0] SEGS = 7'h3F
) (
  input  logic        clk,
  input  logic [4:0]  row,
  input  logic [4:0]  col,
  output logic [11:0] color_data
);

  function automatic logic in_box(input logic [4:0] r, input logic [4:0] c,
                                  input int r0, input int r1, input int c0, input int c1);
    return (int'(r) >= r0) && (int'(r) <= r1) && (int'(c) >= c0) && (int'(c) <= c1);
  endfunction

  logic lit;

  // Segment bits a..g = SEGS[0..6]; lit pixels are black, the rest background.
  always_comb begin
    lit = (SEGS[0] && in_box(row, col,  2,  5,  8, 23)) ||
          (SEGS[1] && in_box(row, col,  4, 15, 22, 25)) ||
          (SEGS[2] && in_box(row, col, 16, 27, 22, 25)) ||
          (SEGS[3] && in_box(row, col, 26, 29,  8, 23)) ||
          (SEGS[4] && in_box(row, col, 16, 27,  6,  9)) ||
          (SEGS[5] && in_box(row, col,  4, 15,  6,  9)) ||
          (SEGS[6] && in_box(row, col, 14, 17,  8, 23));
  end

  always_ff @(posedge clk) begin
    color_data <= lit ? 12'h000 : BG_COLOR;
  end

endmodule

module digit_rom_bank
  import score_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  row,
  input  logic [4:0]  col,
  input  logic [3:0]  sel,
  output logic [11:0] color_data
);

  logic [11:0] px [10];
  logic [3:0]  sel_q;

  digit_rom #(.SEGS(7'h3F)) zero_rom  (.clk(clk), .row(row), .col(col), .color_data(px[0]));
  digit_rom #(.SEGS(7'h06)) one_rom   (.clk(clk), .row(row), .col(col), .color_data(px[1]));
  digit_rom #(.SEGS(7'h5B)) two_rom   (.clk(clk), .row(row), .col(col), .color_data(px[2]));
  digit_rom #(.SEGS(7'h4F)) three_rom (.clk(clk), .row(row), .col(col), .color_data(px[3]));
  digit_rom #(.SEGS(7'h66)) four_rom  (.clk(clk), .row(row), .col(col), .color_data(px[4]));
  digit_rom #(.SEGS(7'h6D)) five_rom  (.clk(clk), .row(row), .col(col), .color_data(px[5]));
  digit_rom #(.SEGS(7'h7D)) six_rom   (.clk(clk), .row(row), .col(col), .color_data(px[6]));
  digit_rom #(.SEGS(7'h07)) seven_rom (.clk(clk), .row(row), .col(col), .color_data(px[7]));
  digit_rom #(.SEGS(7'h7F)) eight_rom (.clk(clk), .row(row), .col(col), .color_data(px[8]));
  digit_rom #(.SEGS(7'h6F)) nine_rom  (.clk(clk), .row(row), .col(col), .color_data(px[9]));

  always_ff @(posedge clk) begin
    if (reset) sel_q <= 4'd0;
    else       sel_q <= sel;
  end

  always_comb begin
    color_data = BG_COLOR;
    if (sel_q <= 4'd9) color_data = px[sel_q];
  end

endmodule

// File: rtl/score_display_ctrl.sv
// BCD score with frame-synchronised commit and 1-cycle pixel overlay of the
// digit sprites; increments accumulate in a saturating pending counter.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter logic [9:0]  X0            = 10'd16,
  parameter logic [9:0]  Y0            = 10'd16,
  parameter int          NUM_DIGITS    = 4,
  parameter int          BLANK_LEADING = 1,
  parameter logic [11:0] FG_COLOR      = 12'h0F0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        score_inc,
  input  logic        score_clr,
  output logic        score_on,
  output logic [11:0] score_rgb,
  output logic [15:0] score_bcd,
  output logic        busy
);

  localparam logic [9:0] X1 = X0 + 10'(DIGIT_W * NUM_DIGITS);
  localparam logic [9:0] Y1 = Y0 + 10'(DIGIT_H);

  state_t      state, state_nxt;
  logic [15:0] work, disp;
  logic [3:0]  pending, apply_cnt;
  logic        clr_pend;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (frame_tick) begin
          if (clr_pend)             state_nxt = ST_CLEAR;
          else if (pending != 4'd0) state_nxt = ST_APPLY;
        end
      end
      ST_CLEAR: state_nxt = ST_COMMIT;
      // Leave once the counter would drain, or after 15 cycles to bound busy.
      ST_APPLY: begin
        if ((pending == 4'd1 && !score_inc) || apply_cnt == 4'd14) state_nxt = ST_COMMIT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work      <= 16'h0000;
      disp      <= 16'h0000;
      pending   <= 4'd0;
      clr_pend  <= 1'b0;
      apply_cnt <= 4'd0;
    end else begin
      clr_pend  <= score_clr || (clr_pend && state != ST_CLEAR);
      apply_cnt <= 4'd0;
      case (state)
        ST_CLEAR: begin
          work    <= 16'h0000;
          pending <= 4'd0;
        end
        ST_APPLY: begin
          work      <= bcd_inc(work);
          pending   <= pending - 4'd1 + {3'd0, score_inc};
          apply_cnt <= apply_cnt + 4'd1;
        end
        default: begin
          if (state == ST_COMMIT) disp <= work;
          if (score_inc && pending != 4'hF) pending <= pending + 4'd1;
        end
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign score_bcd = disp;

  logic [9:0] rel_x;
  logic [4:0] digit_idx, rom_row;
  logic [3:0] digit_val, nib;
  logic       in_field, blank, lead, lead_now, hit, hit_q;
  logic [11:0] rom_color;

  assign rel_x     = pixel_x - X0;
  assign digit_idx = rel_x[9:5];
  assign rom_row   = pixel_y[4:0] - Y0[4:0];
  assign in_field  = video_on && (pixel_x >= X0) && (pixel_x < X1) &&
                     (pixel_y >= Y0) && (pixel_y < Y1);

  // Walk digits from most significant; a digit is blank while every digit up
  // to and including it is zero, except the last one which always shows.
  always_comb begin
    digit_val = 4'd0;
    blank     = 1'b0;
    lead      = 1'b1;
    nib       = 4'd0;
    lead_now  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib      = disp[(NUM_DIGITS-1-i)*4 +: 4];
      lead_now = lead && (nib == 4'd0) && (i != NUM_DIGITS - 1);
      if (digit_idx == 5'(i)) begin
        digit_val = nib;
        blank     = (BLANK_LEADING != 0) && lead_now;
      end
      lead = lead_now;
    end
  end

  assign hit = in_field && !blank;

  always_ff @(posedge clk) begin
    if (reset) hit_q <= 1'b0;
    else       hit_q <= hit;
  end

  digit_rom_bank u_rom_bank (
    .clk        (clk),
    .reset      (reset),
    .row        (rom_row),
    .col        (rel_x[4:0]),
    .sel        (digit_val),
    .color_data (rom_color)
  );

  assign score_on  = hit_q && (rom_color != BG_COLOR);
  assign score_rgb = score_on ? FG_COLOR : 12'h000;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench: expected scores/busy lengths and pixel results are queued
// as stimulus is driven and compared when the DUT commits or draws.
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, frame_tick, score_inc, score_clr;
  logic        score_on;
  logic [11:0] score_rgb;
  logic [15:0] score_bcd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int m_score   = 0;
  int m_pending = 0;
  bit m_clr     = 0;

  logic [15:0] exp_score_q [$];
  int          exp_busy_q  [$];
  logic [12:0] exp_px_q    [$];

  always #5 clk = ~clk;

  score_display_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .score_inc  (score_inc),
    .score_clr  (score_clr),
    .score_on   (score_on),
    .score_rgb  (score_rgb),
    .score_bcd  (score_bcd),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  function automatic bit in_rect(input int r, input int c, input int r0, input int r1,
                                 input int c0, input int c1);
    return r >= r0 && r <= r1 && c >= c0 && c <= c1;
  endfunction

  // Seven-segment glyph: which of a..g each digit lights.
  function automatic bit glyph(input int d, input int r, input int c);
    bit a, b, cc, dd, e, f, g;
    a  = (d != 1 && d != 4);
    b  = (d != 5 && d != 6);
    cc = (d != 2);
    dd = (d != 1 && d != 4 && d != 7);
    e  = (d == 0 || d == 2 || d == 6 || d == 8);
    f  = (d != 1 && d != 2 && d != 3 && d != 7);
    g  = (d >= 2 && d != 7);
    return (a  && in_rect(r, c,  2,  5,  8, 23)) || (b && in_rect(r, c,  4, 15, 22, 25)) ||
           (cc && in_rect(r, c, 16, 27, 22, 25)) || (dd && in_rect(r, c, 26, 29,  8, 23)) ||
           (e  && in_rect(r, c, 16, 27,  6,  9)) || (f && in_rect(r, c,  4, 15,  6,  9)) ||
           (g  && in_rect(r, c, 14, 17,  8, 23));
  endfunction

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      score_inc = 1'b1;
      step();
    end
    score_inc = 1'b0;
    m_pending = (m_pending + n > 15) ? 15 : m_pending + n;
  endtask

  task automatic pulse_clr();
    score_clr = 1'b1;
    step();
    score_clr = 1'b0;
    m_clr = 1;
  endtask

  // One frame update; optional inc during the CLEAR cycle or the 2nd APPLY cycle.
  task automatic run_frame(input string tag, input bit inc_clear, input bit inc_apply2);
    int applied, busy_cnt, exp_b;
    bit prev_busy, popped;
    if (m_clr) begin
      m_score = 0; m_pending = 0; m_clr = 0;
      exp_busy_q.push_back(2);
    end else if (m_pending == 0) begin
      exp_busy_q.push_back(0);
    end else begin
      applied = m_pending + ((inc_apply2 && m_pending >= 2) ? 1 : 0);
      m_pending = 0;
      m_score = (m_score + applied > 9999) ? 9999 : m_score + applied;
      exp_busy_q.push_back(applied + 1);
    end
    exp_score_q.push_back(to_bcd(m_score));
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    busy_cnt = 0; prev_busy = 0; popped = 0;
    for (int k = 0; k < 20; k++) begin
      score_inc = (inc_clear && k == 0) || (inc_apply2 && k == 1);
      if (busy) busy_cnt++;
      if (prev_busy && !busy && !popped) begin
        check({tag, "_score"}, 32'(score_bcd), 32'(exp_score_q.pop_front()));
        popped = 1;
      end
      prev_busy = busy;
      step();
      score_inc = 1'b0;
    end
    if (!popped) check({tag, "_score"}, 32'(score_bcd), 32'(exp_score_q.pop_front()));
    exp_b = exp_busy_q.pop_front();
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_b));
  endtask

  task automatic raster();
    int dig, exp_d, digs[4];
    bit on;
    digs[0] = (m_score / 1000) % 10; digs[1] = (m_score / 100) % 10;
    digs[2] = (m_score / 10) % 10;   digs[3] = m_score % 10;
    for (int y = 10; y < 52; y++) begin
      for (int x = 8; x < 150; x++) begin
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = (y != 20);
        on = 0;
        if (video_on && x >= 16 && x < 144 && y >= 16 && y < 48) begin
          dig = (x - 16) / 32;
          exp_d = digs[dig];
          if (!(dig == 0 && digs[0] == 0) &&
              !(dig == 1 && digs[0] == 0 && digs[1] == 0) &&
              !(dig == 2 && digs[0] == 0 && digs[1] == 0 && digs[2] == 0))
            on = glyph(exp_d, y - 16, (x - 16) % 32);
        end
        exp_px_q.push_back({on, on ? 12'h0F0 : 12'h000});
        step();
        check("pixel", 32'({score_on, score_rgb}), 32'(exp_px_q.pop_front()));
      end
    end
  endtask

  initial begin
    reset = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    frame_tick = 1'b0; score_inc = 1'b0; score_clr = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_on", 32'(score_on), 32'd0);
    check("rst_rgb", 32'(score_rgb), 32'h0);

    pulse_inc(3);
    run_frame("inc3", 0, 0);

    pulse_inc(5);
    pulse_clr();
    run_frame("clear", 1, 0);
    run_frame("after_clear", 0, 0);

    pulse_inc(20);
    run_frame("sat20", 0, 0);

    pulse_inc(3);
    run_frame("inc_in_apply", 0, 1);

    pulse_clr();
    run_frame("clr2", 0, 0);
    pulse_inc(15); run_frame("to42a", 0, 0);
    pulse_inc(15); run_frame("to42b", 0, 0);
    pulse_inc(12); run_frame("to42c", 0, 0);
    check("disp42", 32'(score_bcd), 32'h0042);
    raster();

    while (m_score + 15 <= 999) begin
      pulse_inc(15); run_frame("climb", 0, 0);
    end
    pulse_inc(999 - m_score); run_frame("to999", 0, 0);
    check("disp999", 32'(score_bcd), 32'h0999);
    pulse_inc(1); run_frame("to1000", 0, 0);
    check("disp1000", 32'(score_bcd), 32'h1000);
    while (m_score + 15 <= 9999) begin
      pulse_inc(15); run_frame("climb", 0, 0);
    end
    pulse_inc(9999 - m_score); run_frame("to9999", 0, 0);
    pulse_inc(1); run_frame("sat9999", 0, 0);
    check("disp9999", 32'(score_bcd), 32'h9999);

    pulse_inc(10);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); step();
    check("mid_apply_busy", 32'(busy), 32'd1);
    pixel_x = 10'd24; pixel_y = 10'd20; video_on = 1'b1;
    reset = 1'b1; step(); reset = 1'b0;
    m_score = 0; m_pending = 0; m_clr = 0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_score", 32'(score_bcd), 32'h0);
    check("rst_mid_on", 32'(score_on), 32'd0);
    video_on = 1'b0;
    run_frame("after_rst", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
